decode_execute_core: RTL and testbench
======================================

Name: decode_execute_core

Overview:
- ARM-subset processor slice: Instruction Decode (register file, control unit, condition check), ID/EX pipeline register, Execute (ALU, operand-2 generator, branch-target adder) and NZCV status register, in one block.
- Sits between the IF/ID register and the EX/MEM register.
- Takes the fetched instruction and PC plus write-back traffic.
- Produces ALU result, branch target, branch-taken, memory/write-back controls and hazard-unit source info.

Parameters:
- none (data width fixed at 32, 15 architectural registers R0-R14).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pc_in  in  32  PC+4 of the instruction in ID
- instruction_in  in  32  instruction in ID
- flush  in  1  clear the ID/EX register on the next edge
- hazard  in  1  zero the decoded controls (bubble)
- writebackEnabled_wb  in  1  register-file write enable
- writebackDestination_wb  in  4  register-file write address
- writebackValue_wb  in  32  register-file write data
- src1  out  4  Rn of the ID instruction
- src2  out  4  Rd if the ID instruction is a store, else Rm
- twoSrc  out  1  (~I) | store, for the ID instruction
- writebackEnabled_exe  out  1  EX-stage write-back enable
- memoryReadEnabled_exe  out  1  EX-stage load
- memoryWriteEnabled_exe  out  1  EX-stage store
- branchTaken  out  1  EX-stage b bit
- destination_exe  out  4  EX-stage Rd
- valRm_exe  out  32  EX-stage store data
- aluResult  out  32  ALU output
- branchAddress  out  32  branch target
- status  out  4  status register {N,Z,C,V}

Behaviour:
- Field map: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shiftOperand[11:0], imm24[23:0].
- Register file:
  - Reset sets Ri = i.
  - Writes occur on the rising edge when writebackEnabled_wb=1 and the address is not 15.
  - Reads are combinational with write-through: a same-cycle write to the read address returns writebackValue_wb.
  - Reading address 15 returns 0.
- Control unit, mode 00 (opcode -> cmd; all with wb=1 and s=S unless noted):
  - MOV 1101 -> 0001
  - MVN 1111 -> 1001
  - ADD 0100 -> 0010
  - ADC 0101 -> 0011
  - SUB 0010 -> 0100
  - SBC 0110 -> 0101
  - AND 0000 -> 0110
  - ORR 1100 -> 0111
  - EOR 0001 -> 1000
  - CMP 1010 -> 0100, wb=0, s=1
  - TST 1000 -> 0110, wb=0, s=1
  - Any other opcode gives all controls 0.
- Control unit, other modes:
  - Mode 01, S=1: LDR, cmd 0010, memRead=1, wb=1.
  - Mode 01, S=0: STR, cmd 0010, memWrite=1.
  - Mode 10: B, b=1, cmd 0000.
  - Mode 11: no-op.
- Condition check:
  - Codes EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL per ARM, evaluated against the current status register.
  - Code 1111 is treated as never.
  - If the condition fails or hazard=1, wb, memRead, memWrite, b, s and cmd are forced to 0.
- ID/EX register:
  - On each rising edge it captures controls, pc, valRn, valRm, I, shiftOperand, imm24, Rd and status.
  - rst or flush clears every field to 0.
  - Latency: an instruction decoded in cycle n drives the EX outputs in cycle n+1.
- Operand-2 (val2):
  - Memory op: zero-extended shiftOperand.
  - I=1: {24'b0, imm8[7:0]} rotated right by 2*rot[11:8].
  - I=0: Rm shifted by shift_imm[11:7] per [6:5]: LSL 00, LSR 01, ASR 10, ROR 11. An amount of 0 means no shift.
- ALU (C_in is the registered status C):
  - 0001: val2
  - 1001: ~val2
  - 0010: Rn+val2
  - 0011: Rn+val2+C_in
  - 0100: Rn-val2
  - 0101: Rn-val2-~C_in
  - 0110: and
  - 0111: or
  - 1000: xor
  - others: 0
- Flags:
  - N = result[31]; Z = (result==0).
  - ADD/ADC: C = carry out of bit 31.
  - SUB/SBC: C = no-borrow.
  - V: signed overflow for arithmetic ops.
  - Logic and move ops keep C and V from the registered status.
- branchAddress = pc + (sign-extended imm24 << 2), 32-bit wrap-around.
- Status register:
  - Updates to the ALU flags on the rising edge when EX s=1.
  - Reset value is 0.

Test Plan:
- Reset, then decode MOV R0,#20 (0xE3A00014) -> next cycle aluResult=20, writebackEnabled_exe=1, destination_exe=0.
- Write back R1=5, then decode ADD R2,R1,R1,LSL#2 -> aluResult=25.
- CMP R1,#5 with R1=5 -> status becomes Z=1, C=1; a following MOVNE gets all controls 0.
- B with imm24=0xFFFFFE at pc_in=0x100 -> branchTaken=1, branchAddress=0xF8.
- STR R3,[R0,#8] -> memoryWriteEnabled_exe=1, aluResult=R0+8, src2=3, twoSrc=1.
- flush, or hazard asserted, during ADD -> EX outputs are 0 next cycle and status is unchanged.

Source files
------------

// File: rtl/decode_execute_core_if.sv
// rtl/decode_execute_core_if.sv - decode/execute slice bus: ID inputs, write-back traffic, EX and hazard outputs
interface decode_execute_core_if;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic        flush;
    logic        hazard;
    logic        writebackEnabled_wb;
    logic [3:0]  writebackDestination_wb;
    logic [31:0] writebackValue_wb;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        twoSrc;
    logic        writebackEnabled_exe;
    logic        memoryReadEnabled_exe;
    logic        memoryWriteEnabled_exe;
    logic        branchTaken;
    logic [3:0]  destination_exe;
    logic [31:0] valRm_exe;
    logic [31:0] aluResult;
    logic [31:0] branchAddress;
    logic [3:0]  status;

    modport slave (
        input  pc_in, instruction_in, flush, hazard,
               writebackEnabled_wb, writebackDestination_wb, writebackValue_wb,
        output src1, src2, twoSrc, writebackEnabled_exe, memoryReadEnabled_exe,
               memoryWriteEnabled_exe, branchTaken, destination_exe, valRm_exe,
               aluResult, branchAddress, status
    );

    modport master (
        output pc_in, instruction_in, flush, hazard,
               writebackEnabled_wb, writebackDestination_wb, writebackValue_wb,
        input  src1, src2, twoSrc, writebackEnabled_exe, memoryReadEnabled_exe,
               memoryWriteEnabled_exe, branchTaken, destination_exe, valRm_exe,
               aluResult, branchAddress, status
    );
endinterface

// File: rtl/decode_execute_core.sv
// rtl/decode_execute_core.sv - ARM-subset ID stage, ID/EX register, EX stage and NZCV status register
module decode_execute_core (
    input  logic                   clk,
    input  logic                   rst,
    decode_execute_core_if.slave   bus
);
    logic [3:0]  cond, opcode, rn, rd;
    logic [1:0]  mode;
    logic        imm_bit, s_bit, is_store;
    logic [31:0] rf_q [0:14];
    logic [31:0] val_rn_d, val_rm_d;
    logic        cond_ok;
    logic [3:0]  status_q;
    logic        n_f, z_f, c_f, v_f;

    logic        wb_d, mr_d, mw_d, b_d, s_d;
    logic [3:0]  cmd_d;

    logic        wb_q, mr_q, mw_q, b_q, s_q, imm_q;
    logic [3:0]  cmd_q, rd_q;
    logic [1:0]  cv_q;
    logic [31:0] pc_q, val_rn_q, val_rm_q;
    logic [23:0] imm24_q;

    logic [31:0] val2, alu_res;
    logic [32:0] sum;
    logic        alu_c, alu_v;
    logic [11:0] shift_op;
    logic [4:0]  shamt;

    assign cond     = bus.instruction_in[31:28];
    assign mode     = bus.instruction_in[27:26];
    assign imm_bit  = bus.instruction_in[25];
    assign opcode   = bus.instruction_in[24:21];
    assign s_bit    = bus.instruction_in[20];
    assign rn       = bus.instruction_in[19:16];
    assign rd       = bus.instruction_in[15:12];
    assign is_store = (mode == 2'b01) && !s_bit;

    assign bus.src1   = rn;
    assign bus.src2   = is_store ? rd : bus.instruction_in[3:0];
    assign bus.twoSrc = !imm_bit || is_store;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
        if (r == 5'd0) return x;
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

    // Reads bypass a same-cycle write so WB results are visible without an extra stall.
    always_comb begin
        val_rn_d = 32'd0;
        val_rm_d = 32'd0;
        if (rn != 4'd15)
            val_rn_d = (bus.writebackEnabled_wb && bus.writebackDestination_wb == rn)
                       ? bus.writebackValue_wb : rf_q[rn];
        if (bus.src2 != 4'd15)
            val_rm_d = (bus.writebackEnabled_wb && bus.writebackDestination_wb == bus.src2)
                       ? bus.writebackValue_wb : rf_q[bus.src2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                rf_q[i] <= 32'(i);
        end else if (bus.writebackEnabled_wb && bus.writebackDestination_wb != 4'd15) begin
            rf_q[bus.writebackDestination_wb] <= bus.writebackValue_wb;
        end
    end

    assign {n_f, z_f, c_f, v_f} = status_q;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f && !z_f;
            4'b1001: cond_ok = !c_f || z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f && (n_f == v_f);
            4'b1101: cond_ok = z_f || (n_f != v_f);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        wb_d  = 1'b0;
        mr_d  = 1'b0;
        mw_d  = 1'b0;
        b_d   = 1'b0;
        s_d   = 1'b0;
        cmd_d = 4'b0000;
        case (mode)
            2'b00: begin
                wb_d = 1'b1;
                s_d  = s_bit;
                case (opcode)
                    4'b1101: cmd_d = 4'b0001;
                    4'b1111: cmd_d = 4'b1001;
                    4'b0100: cmd_d = 4'b0010;
                    4'b0101: cmd_d = 4'b0011;
                    4'b0010: cmd_d = 4'b0100;
                    4'b0110: cmd_d = 4'b0101;
                    4'b0000: cmd_d = 4'b0110;
                    4'b1100: cmd_d = 4'b0111;
                    4'b0001: cmd_d = 4'b1000;
                    4'b1010: begin cmd_d = 4'b0100; wb_d = 1'b0; s_d = 1'b1; end
                    4'b1000: begin cmd_d = 4'b0110; wb_d = 1'b0; s_d = 1'b1; end
                    default: begin wb_d = 1'b0; s_d = 1'b0; end
                endcase
            end
            2'b01: begin
                cmd_d = 4'b0010;
                mr_d  = s_bit;
                wb_d  = s_bit;
                mw_d  = !s_bit;
            end
            2'b10: b_d = 1'b1;
            default: ;
        endcase
        if (!cond_ok || bus.hazard) begin
            wb_d  = 1'b0;
            mr_d  = 1'b0;
            mw_d  = 1'b0;
            b_d   = 1'b0;
            s_d   = 1'b0;
            cmd_d = 4'b0000;
        end
    end

    // Only C and V of the captured status are consumed in EX (carry-in and flag retention).
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wb_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            b_q      <= 1'b0;
            s_q      <= 1'b0;
            imm_q    <= 1'b0;
            cmd_q    <= 4'd0;
            rd_q     <= 4'd0;
            cv_q     <= 2'd0;
            pc_q     <= 32'd0;
            val_rn_q <= 32'd0;
            val_rm_q <= 32'd0;
            imm24_q  <= 24'd0;
        end else begin
            wb_q     <= wb_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            b_q      <= b_d;
            s_q      <= s_d;
            imm_q    <= imm_bit;
            cmd_q    <= cmd_d;
            rd_q     <= rd;
            cv_q     <= {c_f, v_f};
            pc_q     <= bus.pc_in;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
            imm24_q  <= bus.instruction_in[23:0];
        end
    end

    assign shift_op = imm24_q[11:0];
    assign shamt    = shift_op[11:7];

    always_comb begin
        val2 = val_rm_q;
        if (mr_q || mw_q)
            val2 = {20'd0, shift_op};
        else if (imm_q)
            val2 = ror32({24'd0, shift_op[7:0]}, {shift_op[11:8], 1'b0});
        else if (shamt != 5'd0) begin
            case (shift_op[6:5])
                2'b00:   val2 = val_rm_q << shamt;
                2'b01:   val2 = val_rm_q >> shamt;
                2'b10:   val2 = 32'($signed(val_rm_q) >>> shamt);
                default: val2 = ror32(val_rm_q, shamt);
            endcase
        end
    end

    // Subtraction is a + ~b + 1 so that the adder carry-out is directly the no-borrow flag.
    always_comb begin
        alu_res = 32'd0;
        sum     = 33'd0;
        alu_c   = cv_q[1];
        alu_v   = cv_q[0];
        case (cmd_q)
            4'b0001: alu_res = val2;
            4'b1001: alu_res = ~val2;
            4'b0010, 4'b0011: begin
                sum     = {1'b0, val_rn_q} + {1'b0, val2} + {32'd0, cmd_q[0] & cv_q[1]};
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (val_rn_q[31] == val2[31]) && (alu_res[31] != val_rn_q[31]);
            end
            4'b0100, 4'b0101: begin
                sum     = {1'b0, val_rn_q} + {1'b0, ~val2} + {32'd0, cmd_q[0] ? cv_q[1] : 1'b1};
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (val_rn_q[31] != val2[31]) && (alu_res[31] != val_rn_q[31]);
            end
            4'b0110: alu_res = val_rn_q & val2;
            4'b0111: alu_res = val_rn_q | val2;
            4'b1000: alu_res = val_rn_q ^ val2;
            default: alu_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            status_q <= 4'd0;
        else if (s_q)
            status_q <= {alu_res[31], alu_res == 32'd0, alu_c, alu_v};
    end

    assign bus.writebackEnabled_exe   = wb_q;
    assign bus.memoryReadEnabled_exe  = mr_q;
    assign bus.memoryWriteEnabled_exe = mw_q;
    assign bus.branchTaken            = b_q;
    assign bus.destination_exe        = rd_q;
    assign bus.valRm_exe              = val_rm_q;
    assign bus.aluResult              = alu_res;
    assign bus.branchAddress          = pc_q + {{6{imm24_q[23]}}, imm24_q, 2'b00};
    assign bus.status                 = status_q;
endmodule

// File: tb/tb_decode_execute_core.sv
// tb/tb_decode_execute_core.sv - directed self-checking bench for decode_execute_core
module tb_decode_execute_core;
    localparam logic [31:0] NOP = 32'hF000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    decode_execute_core_if bus();

    decode_execute_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        bus.instruction_in = ins;
        bus.pc_in          = pc;
        @(posedge clk);
        #1;
        bus.instruction_in      = NOP;
        bus.writebackEnabled_wb = 1'b0;
    endtask

    task automatic set_wb(input logic [3:0] dst, input logic [31:0] val);
        bus.writebackEnabled_wb     = 1'b1;
        bus.writebackDestination_wb = dst;
        bus.writebackValue_wb       = val;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.instruction_in = NOP;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.status !== 4'd0) begin bad++; $display("FAIL reset_status got=%h want=0", bus.status); end
        total++; if (bus.writebackEnabled_exe !== 1'b0) begin bad++; $display("FAIL reset_wb got=%b want=0", bus.writebackEnabled_exe); end
        total++; if (bus.aluResult !== 32'd0) begin bad++; $display("FAIL reset_alu got=%h want=0", bus.aluResult); end
        total++; if (bus.branchAddress !== 32'd0) begin bad++; $display("FAIL reset_baddr got=%h want=0", bus.branchAddress); end
        rst = 1'b0;
    endtask

    task automatic test_mov_imm;
        issue(32'hE3A00014, 32'd4);
        total++; if (bus.aluResult !== 32'd20) begin bad++; $display("FAIL mov_imm_alu got=%h want=14", bus.aluResult); end
        total++; if (bus.writebackEnabled_exe !== 1'b1) begin bad++; $display("FAIL mov_imm_wb got=%b want=1", bus.writebackEnabled_exe); end
        total++; if (bus.destination_exe !== 4'd0) begin bad++; $display("FAIL mov_imm_dst got=%h want=0", bus.destination_exe); end
        issue(32'hE3A0043F, 32'd8);
        total++; if (bus.aluResult !== 32'h3F00_0000) begin bad++; $display("FAIL mov_rot_alu got=%h want=3f000000", bus.aluResult); end
    endtask

    task automatic test_add_shift;
        set_wb(4'd1, 32'd5);
        issue(NOP, 32'd0);
        issue(32'hE0812101, 32'd12);
        total++; if (bus.aluResult !== 32'd25) begin bad++; $display("FAIL add_lsl_alu got=%h want=19", bus.aluResult); end
        total++; if (bus.destination_exe !== 4'd2) begin bad++; $display("FAIL add_lsl_dst got=%h want=2", bus.destination_exe); end
        issue(32'hE0612001, 32'd16);
        total++; if (bus.writebackEnabled_exe !== 1'b0) begin bad++; $display("FAIL bad_opcode_wb got=%b want=0", bus.writebackEnabled_exe); end
    endtask

    task automatic test_cmp_cond;
        bus.instruction_in = 32'hE3510005;
        #1;
        total++; if (bus.src1 !== 4'd1) begin bad++; $display("FAIL cmp_src1 got=%h want=1", bus.src1); end
        total++; if (bus.twoSrc !== 1'b0) begin bad++; $display("FAIL cmp_twosrc got=%b want=0", bus.twoSrc); end
        issue(32'hE3510005, 32'd20);
        total++; if (bus.writebackEnabled_exe !== 1'b0) begin bad++; $display("FAIL cmp_wb got=%b want=0", bus.writebackEnabled_exe); end
        issue(NOP, 32'd24);
        total++; if (bus.status !== 4'b0110) begin bad++; $display("FAIL cmp_status got=%b want=0110", bus.status); end
        issue(32'h13A04001, 32'd28);
        total++; if (bus.writebackEnabled_exe !== 1'b0) begin bad++; $display("FAIL movne_wb got=%b want=0", bus.writebackEnabled_exe); end
        total++; if (bus.aluResult !== 32'd0) begin bad++; $display("FAIL movne_alu got=%h want=0", bus.aluResult); end
        issue(32'h03A04001, 32'd32);
        total++; if (bus.writebackEnabled_exe !== 1'b1) begin bad++; $display("FAIL moveq_wb got=%b want=1", bus.writebackEnabled_exe); end
        total++; if (bus.aluResult !== 32'd1) begin bad++; $display("FAIL moveq_alu got=%h want=1", bus.aluResult); end
    endtask

    task automatic test_adc_subs;
        issue(32'hE2A15000, 32'd36);
        total++; if (bus.aluResult !== 32'd6) begin bad++; $display("FAIL adc_alu got=%h want=6", bus.aluResult); end
        issue(32'hE2516006, 32'd40);
        total++; if (bus.aluResult !== 32'hFFFF_FFFF) begin bad++; $display("FAIL subs_alu got=%h want=ffffffff", bus.aluResult); end
        issue(NOP, 32'd44);
        total++; if (bus.status !== 4'b1000) begin bad++; $display("FAIL subs_status got=%b want=1000", bus.status); end
    endtask

    task automatic test_branch;
        issue(32'hEAFFFFFE, 32'h100);
        total++; if (bus.branchTaken !== 1'b1) begin bad++; $display("FAIL b_taken got=%b want=1", bus.branchTaken); end
        total++; if (bus.branchAddress !== 32'hF8) begin bad++; $display("FAIL b_addr got=%h want=f8", bus.branchAddress); end
        total++; if (bus.writebackEnabled_exe !== 1'b0) begin bad++; $display("FAIL b_wb got=%b want=0", bus.writebackEnabled_exe); end
    endtask

    task automatic test_load_store;
        bus.instruction_in = 32'hE5803008;
        #1;
        total++; if (bus.src2 !== 4'd3) begin bad++; $display("FAIL str_src2 got=%h want=3", bus.src2); end
        total++; if (bus.twoSrc !== 1'b1) begin bad++; $display("FAIL str_twosrc got=%b want=1", bus.twoSrc); end
        issue(32'hE5803008, 32'd48);
        total++; if (bus.memoryWriteEnabled_exe !== 1'b1) begin bad++; $display("FAIL str_mw got=%b want=1", bus.memoryWriteEnabled_exe); end
        total++; if (bus.aluResult !== 32'd8) begin bad++; $display("FAIL str_alu got=%h want=8", bus.aluResult); end
        total++; if (bus.valRm_exe !== 32'd3) begin bad++; $display("FAIL str_valrm got=%h want=3", bus.valRm_exe); end
        issue(32'hE5907004, 32'd52);
        total++; if (bus.memoryReadEnabled_exe !== 1'b1) begin bad++; $display("FAIL ldr_mr got=%b want=1", bus.memoryReadEnabled_exe); end
        total++; if (bus.writebackEnabled_exe !== 1'b1) begin bad++; $display("FAIL ldr_wb got=%b want=1", bus.writebackEnabled_exe); end
        total++; if (bus.aluResult !== 32'd4) begin bad++; $display("FAIL ldr_alu got=%h want=4", bus.aluResult); end
        total++; if (bus.destination_exe !== 4'd7) begin bad++; $display("FAIL ldr_dst got=%h want=7", bus.destination_exe); end
    endtask

    task automatic test_flush_hazard;
        bus.flush = 1'b1;
        issue(32'hE0912001, 32'd56);
        bus.flush = 1'b0;
        total++; if (bus.writebackEnabled_exe !== 1'b0) begin bad++; $display("FAIL flush_wb got=%b want=0", bus.writebackEnabled_exe); end
        total++; if (bus.destination_exe !== 4'd0) begin bad++; $display("FAIL flush_dst got=%h want=0", bus.destination_exe); end
        total++; if (bus.aluResult !== 32'd0) begin bad++; $display("FAIL flush_alu got=%h want=0", bus.aluResult); end
        issue(NOP, 32'd60);
        total++; if (bus.status !== 4'b1000) begin bad++; $display("FAIL flush_status got=%b want=1000", bus.status); end
        bus.hazard = 1'b1;
        issue(32'hE0912001, 32'd64);
        bus.hazard = 1'b0;
        total++; if (bus.writebackEnabled_exe !== 1'b0) begin bad++; $display("FAIL hazard_wb got=%b want=0", bus.writebackEnabled_exe); end
        total++; if (bus.aluResult !== 32'd0) begin bad++; $display("FAIL hazard_alu got=%h want=0", bus.aluResult); end
        issue(NOP, 32'd68);
        total++; if (bus.status !== 4'b1000) begin bad++; $display("FAIL hazard_status got=%b want=1000", bus.status); end
        issue(32'hE0912001, 32'd72);
        total++; if (bus.aluResult !== 32'd10) begin bad++; $display("FAIL adds_alu got=%h want=a", bus.aluResult); end
        issue(NOP, 32'd76);
        total++; if (bus.status !== 4'b0000) begin bad++; $display("FAIL adds_status got=%b want=0000", bus.status); end
    endtask

    task automatic test_write_through;
        set_wb(4'd8, 32'h1234);
        issue(32'hE1A09008, 32'd80);
        total++; if (bus.aluResult !== 32'h1234) begin bad++; $display("FAIL bypass_alu got=%h want=1234", bus.aluResult); end
        set_wb(4'd15, 32'hDEAD);
        issue(32'hE1A0A00F, 32'd84);
        total++; if (bus.aluResult !== 32'd0) begin bad++; $display("FAIL r15_alu got=%h want=0", bus.aluResult); end
        set_wb(4'd12, 32'h8000_0000);
        issue(32'hE1A0B0CC, 32'd88);
        total++; if (bus.aluResult !== 32'hC000_0000) begin bad++; $display("FAIL asr_alu got=%h want=c0000000", bus.aluResult); end
        issue(32'hE1A0022C, 32'd92);
        total++; if (bus.aluResult !== 32'h0800_0000) begin bad++; $display("FAIL lsr_alu got=%h want=08000000", bus.aluResult); end
        issue(32'hE1A000E1, 32'd96);
        total++; if (bus.aluResult !== 32'h8000_0002) begin bad++; $display("FAIL ror_alu got=%h want=80000002", bus.aluResult); end
    endtask

    initial begin
        bus.pc_in                   = 32'd0;
        bus.instruction_in          = NOP;
        bus.flush                   = 1'b0;
        bus.hazard                  = 1'b0;
        bus.writebackEnabled_wb     = 1'b0;
        bus.writebackDestination_wb = 4'd0;
        bus.writebackValue_wb       = 32'd0;
        test_reset();
        test_mov_imm();
        test_add_shift();
        test_cmp_cond();
        test_adc_subs();
        test_branch();
        test_load_store();
        test_flush_hazard();
        test_write_through();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
